// File: rtl/hamming_pkg.sv
// Shared widths, sizing helper and FSM state type for the Hamming-distance stream controller.
package hamming_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_WORDS = 256;

  // Bits needed to hold any value in 0..v.
  function automatic int unsigned clog2_plus1(input int unsigned v);
    return $clog2(v + 1);
  endfunction

  localparam int unsigned PC_W  = clog2_plus1(WORD_W);
  localparam int unsigned LEN_W = clog2_plus1(MAX_WORDS);
  localparam int unsigned ACC_W = clog2_plus1(WORD_W * MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hamming_stream_ctrl_if.sv
// Job/operand/result handshake bundle; thresh/res_over exist only with HAMMING_THRESH_EN.
interface hamming_stream_ctrl_if;
  import hamming_pkg::*;

  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             in_valid;
  logic             in_ready;
  logic [WORD_W-1:0] a_data;
  logic [WORD_W-1:0] b_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_dist;
`ifdef HAMMING_THRESH_EN
  logic [ACC_W-1:0] thresh;
  logic             res_over;

  modport master (
    output start_valid, start_len, in_valid, a_data, b_data, res_ready, thresh,
    input  start_ready, in_ready, res_valid, res_dist, res_over
  );
  modport slave (
    input  start_valid, start_len, in_valid, a_data, b_data, res_ready, thresh,
    output start_ready, in_ready, res_valid, res_dist, res_over
  );
`else
  modport master (
    output start_valid, start_len, in_valid, a_data, b_data, res_ready,
    input  start_ready, in_ready, res_valid, res_dist
  );
  modport slave (
    input  start_valid, start_len, in_valid, a_data, b_data, res_ready,
    output start_ready, in_ready, res_valid, res_dist
  );
`endif
endinterface

// File: rtl/hamming_popcount_core.sv
// Combinational Hamming distance of two words: popcount(a ^ b).
module hamming_popcount_core
  import hamming_pkg::*;
#(
  parameter int unsigned W  = WORD_W,
  parameter int unsigned DW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [DW-1:0] dist_c_o
);

  logic [W-1:0] diff;

  assign diff = a_i ^ b_i;

  always_comb begin
    dist_c_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      dist_c_o = dist_c_o + DW'(diff[i]);
    end
  end

endmodule

// File: rtl/hamming_stream_ctrl.sv
// Sequences a job of (a, b) word pairs through the popcount core and returns the summed distance.
// Optional HAMMING_THRESH_EN adds a latched threshold and a registered res_over flag.
module hamming_stream_ctrl
  import hamming_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  hamming_stream_ctrl_if.slave  bus,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_dist_q, res_dist_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             start_ready_q, start_ready_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic [PC_W-1:0]  word_dist;
  logic             start_fire, in_fire;
`ifdef HAMMING_THRESH_EN
  logic [ACC_W-1:0] thresh_q, thresh_d;
  logic             res_over_q, res_over_d;
`endif

  hamming_popcount_core #(.W(WORD_W), .DW(PC_W)) u_popcount (
    .a_i      (bus.a_data),
    .b_i      (bus.b_data),
    .dist_c_o (word_dist)
  );

  // Handshake flags are registered copies of the state decode, so they qualify acceptance.
  assign start_fire = bus.start_valid & start_ready_q;
  assign in_fire    = bus.in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      rem_q         <= '0;
      res_dist_q    <= '0;
      start_ready_q <= 1'b0;
      in_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef HAMMING_THRESH_EN
      thresh_q      <= '0;
      res_over_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      res_dist_q    <= res_dist_d;
      start_ready_q <= start_ready_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
`ifdef HAMMING_THRESH_EN
      thresh_q      <= thresh_d;
      res_over_q    <= res_over_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    res_dist_d = res_dist_q;
`ifdef HAMMING_THRESH_EN
    thresh_d   = thresh_q;
    res_over_d = res_over_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_fire) begin
          acc_d = '0;
          rem_d = (bus.start_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : bus.start_len;
`ifdef HAMMING_THRESH_EN
          thresh_d = bus.thresh;
`endif
          state_d = (rem_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          acc_d = acc_q + ACC_W'(word_dist);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Result is captured once on entry to DONE and held until the next job completes.
    if (state_d == DONE && state_q != DONE) begin
      res_dist_d = acc_d;
`ifdef HAMMING_THRESH_EN
      res_over_d = (acc_d > thresh_d);
`endif
    end

    start_ready_d = (state_d == IDLE);
    in_ready_d    = (state_d == RUN);
    res_valid_d   = (state_d == DONE);
    busy_d        = (state_d == RUN) || (state_d == DONE);
  end

  assign bus.start_ready = start_ready_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_dist    = res_dist_q;
  assign busy            = busy_q;
`ifdef HAMMING_THRESH_EN
  assign bus.res_over    = res_over_q;
`endif

endmodule

// File: tb/tb_hamming_stream_ctrl.sv
// Directed self-checking bench for hamming_stream_ctrl; threshold cases run with HAMMING_THRESH_EN.
module tb_hamming_stream_ctrl;
  import hamming_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_pass;
  int   viol;
  int   in_seen;

  hamming_stream_ctrl_if bus ();

  hamming_stream_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_ready must never coexist with IDLE (start_ready) or DONE (res_valid).
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_ready && (bus.res_valid || bus.start_ready)) viol++;
      if (bus.in_ready) in_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int thr);
    int n;
    n = 0;
    while (!bus.start_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.start_ready) check_eq("start_ready_timeout", 32'(bus.start_ready), 32'd1);
    bus.start_valid = 1'b1;
    bus.start_len   = LEN_W'(len);
`ifdef HAMMING_THRESH_EN
    bus.thresh      = ACC_W'(thr);
`else
    if (thr != 0) $display("note: threshold %0d ignored in this build", thr);
`endif
    tick();
    bus.start_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.a_data   = a;
    bus.b_data   = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input int exp);
    int n;
    n = 0;
    while (!bus.res_valid && n < 600) begin
      tick();
      n++;
    end
    check_eq({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check_eq({tag, "_res_dist"}, 32'(bus.res_dist), 32'(exp));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    n_checks        = 0;
    n_pass          = 0;
    viol            = 0;
    in_seen         = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.start_len   = '0;
    bus.in_valid    = 1'b0;
    bus.a_data      = '0;
    bus.b_data      = '0;
    bus.res_ready   = 1'b0;
`ifdef HAMMING_THRESH_EN
    bus.thresh      = '0;
`endif

    // Reset values
    tick();
    tick();
    check_eq("rst_start_ready", 32'(bus.start_ready), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_res_dist", 32'(bus.res_dist), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_start_ready", 32'(bus.start_ready), 32'd1);

    // Single word, full distance; result the cycle after the pair is accepted
    start_job(1, 0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    send_pair(32'hFFFF_FFFF, 32'h0000_0000, 0);
    check_eq("t1_latency", 32'(bus.res_valid), 32'd1);
    take_result("t1", 32);

    // Three words with 2-cycle gaps: 1 + 32 + 0
    start_job(3, 0);
    send_pair(32'h0000_0000, 32'h0000_0001, 2);
    send_pair(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2);
    send_pair(32'hAAAA_5555, 32'hAAAA_5555, 2);
    check_eq("t2_latency", 32'(bus.res_valid), 32'd1);
    take_result("t2", 33);

    // Zero-length job
    in_seen = 0;
    start_job(0, 0);
    check_eq("t3_latency", 32'(bus.res_valid), 32'd1);
    take_result("t3", 0);
    check_eq("t3_no_in_ready", 32'(in_seen), 32'd0);

    // Back-to-back with result stalled; second start held through DONE
    start_job(2, 0);
    send_pair(32'h0000_00FF, 32'h0, 0);
    send_pair(32'h0000_0003, 32'h0, 0);
    bus.start_valid = 1'b1;
    bus.start_len   = LEN_W'(1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("t4_hold_dist", 32'(bus.res_dist), 32'd10);
      check_eq("t4_hold_start_ready", 32'(bus.start_ready), 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("t4_hs_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("t4_hs_start_ready", 32'(bus.start_ready), 32'd1);
    tick();
    bus.start_valid = 1'b0;
    check_eq("t4_second_busy", 32'(busy), 32'd1);
    check_eq("t4_second_start_ready", 32'(bus.start_ready), 32'd0);
    send_pair(32'h0000_0007, 32'h0, 0);
    take_result("t4b", 3);

    // Reset in the middle of a 4-word job
    start_job(4, 0);
    send_pair(32'h1, 32'h0, 0);
    send_pair(32'h2, 32'h0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_start_ready", 32'(bus.start_ready), 32'd0);
    check_eq("t5_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("t5_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("t5_res_dist", 32'(bus.res_dist), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (4) begin
      tick();
      if (bus.res_valid) n++;
    end
    check_eq("t5_no_result", 32'(n), 32'd0);
    start_job(1, 0);
    send_pair(32'h1, 32'h0, 0);
    take_result("t5b", 1);

    // Oversized length saturates; all-ones words fill the accumulator range
    start_job(300, 0);
    bus.a_data   = 32'hFFFF_FFFF;
    bus.b_data   = 32'h0;
    bus.in_valid = 1'b1;
    n   = 0;
    cyc = 0;
    while (!bus.res_valid && cyc < 400) begin
      if (bus.in_ready) n++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_eq("t6_words_consumed", 32'(n), 32'd256);
    take_result("t6", 8192);

`ifdef HAMMING_THRESH_EN
    // Distances 8 and 3 against thresholds 10 and 11
    start_job(2, 10);
    send_pair(32'h0000_00FF, 32'h0, 0);
    send_pair(32'h0000_0007, 32'h0, 0);
    check_eq("t7_over", 32'(bus.res_over), 32'd1);
    take_result("t7", 11);
    check_eq("t7_over_hold", 32'(bus.res_over), 32'd1);
    start_job(2, 11);
    send_pair(32'h0000_00FF, 32'h0, 0);
    send_pair(32'h0000_0007, 32'h0, 0);
    check_eq("t8_over", 32'(bus.res_over), 32'd0);
    take_result("t8", 11);
`endif

    tick();
    check_eq("in_ready_outside_run", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_stream_ctrl.md
Name: hamming_stream_ctrl

Overview:
- Sequencer for the 32-bit combinational Hamming-distance datapath.
- Accepts a job descriptor giving the word count, then streams that many (a, b) word pairs through the datapath over a valid/ready interface.
- Accumulates the per-word distances and returns the total on a result handshake.
- Sits between an operand producer (memory reader / garbling front-end) and the result consumer.

Parameters:
- WORD_W, 32, operand word width in bits; the datapath popcount is clog2(WORD_W+1) = 6 bits wide.
- MAX_WORDS, 256, maximum words per job.
- LEN_W, clog2(MAX_WORDS+1) = 9, job length width.
- ACC_W, clog2(WORD_W*MAX_WORDS+1) = 14, accumulator and result width.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_valid  in  1  job descriptor valid.
- start_ready  out  1  controller can accept a job.
- start_len  in  LEN_W  number of word pairs in the job; 0 is legal.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller consumes the pair this cycle.
- a_data  in  WORD_W  operand A word.
- b_data  in  WORD_W  operand B word.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_dist  out  ACC_W  total Hamming distance of the job.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: state=IDLE, acc=0, remaining=0, start_ready=0 in the reset cycle and 1 from the first cycle after, in_ready=0, res_valid=0, res_dist=0, busy=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1, in_ready=0.
  - On start_valid, the descriptor is accepted, acc is cleared and remaining=min(start_len, MAX_WORDS).
  - If remaining is 0 the next state is DONE; otherwise the next state is RUN.
- RUN:
  - in_ready=1, start_ready=0.
  - Each cycle with in_valid, acc += popcount(a_data ^ b_data) (zero-extended to ACC_W) and remaining decrements.
  - On acceptance of the pair that makes remaining 0, the next state is DONE.
  - Cycles with in_valid=0 hold all state; gaps are unlimited.
- DONE:
  - res_valid=1 and res_dist=acc, both stable until res_ready.
  - in_ready=0, start_ready=0.
  - On res_ready the next state is IDLE and res_valid drops the following cycle.
  - A new start is accepted no earlier than the cycle after the result handshake.
- Latency: res_valid rises the cycle after the last pair is accepted, or the cycle after start for a zero-length job. Throughput is one word per cycle.
- Arithmetic: the accumulator cannot overflow with the parameters above.
- Boundary conditions:
  - start_len > MAX_WORDS saturates to MAX_WORDS.
  - start_valid outside IDLE is ignored and not consumed.
  - in_valid in IDLE or DONE is not consumed.
- Reset mid-operation: the job is aborted with no result emitted; any partially streamed operands are the producer's responsibility.
- res_dist outside DONE holds its last value; it is 0 after reset.

Optional Feature:
- Macro: HAMMING_THRESH_EN.
- When defined, the block adds two ports:
  - thresh  in  ACC_W, latched at start acceptance.
  - res_over  out  1, valid with res_valid; equals 1 iff final res_dist > latched thresh. It holds with res_dist and is 0 at reset.
- There is no early termination; the full job is always consumed.
- When not defined, neither port exists and behaviour is otherwise identical.

Decomposition:
- Package hamming_pkg holds:
  - the WORD_W default and the derived ACC_W/LEN_W helper function;
  - the state enum typedef {IDLE, RUN, DONE}.
- Sub-module hamming_popcount_core is the combinational unit: WORD_W-bit a, b in and clog2(WORD_W+1)-bit distance out. It is instantiated once and sits outside the FSM.

Test Plan:
- len=1, a=0xFFFFFFFF, b=0x00000000 -> res_valid one cycle after acceptance, res_dist=32.
- len=3, pairs (0x0,0x1), (0xF0F0F0F0,0x0F0F0F0F), (0xAAAA5555,0xAAAA5555), with in_valid gaps of 2 cycles -> res_dist=33, and in_ready is never high outside RUN.
- len=0 -> res_valid the next cycle, res_dist=0, in_ready never asserted.
- Back-to-back jobs with res_ready held low for 5 cycles:
  - res_valid/res_dist stable and start_ready=0 throughout;
  - the second start is accepted one cycle after the handshake;
  - acc starts from 0 for the second job.
- Reset asserted after 2 of 4 words -> all outputs at reset values next cycle, no res_valid. Then job len=1, a=0x1, b=0x0 -> res_dist=1.
- HAMMING_THRESH_EN, words with distances 8 and 3:
  - thresh=10 -> res_dist=11, res_over=1;
  - thresh=11 -> res_over=0.
  - start_len=300 -> exactly 256 words consumed.
